// File: rtl/set_pkg.sv
// Shared encodings for the SET grid/circle counter.
// Optional three-circle mode is compiled in by defining SET_MODE3_EN.
package set_pkg;

   typedef enum logic [1:0] {
      MODE_A   = 2'b00,
      MODE_AND = 2'b01,
      MODE_XOR = 2'b10,
      MODE_TWO = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [3:0] GRID_MIN = 4'd1;
   localparam logic [3:0] GRID_MAX = 4'd8;
   localparam logic [5:0] LAST_PT  = 6'd63;

endpackage

// File: rtl/set_in_circle.sv
// Combinational inside-circle test for one grid point.
// Squared distance kept at 9 bits so the 15^2+15^2 worst case cannot wrap.
module set_in_circle (
   input  logic [3:0] px,
   input  logic [3:0] py,
   input  logic [3:0] cx,
   input  logic [3:0] cy,
   input  logic [3:0] r,
   output logic       in
);

   logic [3:0] dx_s;
   logic [3:0] dy_s;
   logic [8:0] dsq_s;
   logic [7:0] rsq_s;

   assign dx_s  = (px >= cx) ? (px - cx) : (cx - px);
   assign dy_s  = (py >= cy) ? (py - cy) : (cy - py);
   assign dsq_s = ({5'd0, dx_s} * {5'd0, dx_s}) + ({5'd0, dy_s} * {5'd0, dy_s});
   assign rsq_s = {4'd0, r} * {4'd0, r};
   assign in    = (dsq_s <= {1'b0, rsq_s});

endmodule

// File: rtl/set_core.sv
// SET top: scans the 8x8 grid one point per cycle and counts points matching the set operation.
// Mode 11 (exactly two of A, B, C) exists only when SET_MODE3_EN is defined; otherwise it counts zero.
module set_core
   import set_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [23:0] central,
   input  logic [11:0] radius,
   input  logic [1:0]  mode,
   output logic        busy,
   output logic        valid,
   output logic [7:0]  candidate
);

   state_e      state_r;
   mode_e       mode_r;
   logic [23:0] cen_r;
   logic [11:0] rad_r;
   logic [5:0]  pt_r;
   logic [6:0]  cnt_r;
   logic [7:0]  cand_r;
   logic        busy_r;
   logic        valid_r;

   logic [3:0]  px_s;
   logic [3:0]  py_s;
   logic        in_a_s;
   logic        in_b_s;
   logic        hit_s;

   // Raster order: low three counter bits walk x, high three walk y.
   assign px_s = {1'b0, pt_r[2:0]} + GRID_MIN;
   assign py_s = {1'b0, pt_r[5:3]} + GRID_MIN;

   set_in_circle u_in_a (
      .px(px_s), .py(py_s), .cx(cen_r[23:20]), .cy(cen_r[19:16]), .r(rad_r[11:8]), .in(in_a_s)
   );

   set_in_circle u_in_b (
      .px(px_s), .py(py_s), .cx(cen_r[15:12]), .cy(cen_r[11:8]), .r(rad_r[7:4]), .in(in_b_s)
   );

`ifdef SET_MODE3_EN
   logic in_c_s;

   set_in_circle u_in_c (
      .px(px_s), .py(py_s), .cx(cen_r[7:4]), .cy(cen_r[3:0]), .r(rad_r[3:0]), .in(in_c_s)
   );
`else
   logic unused_c_s;
   assign unused_c_s = ^{cen_r[7:0], rad_r[3:0]};
`endif

   // Per-point membership for the selected set operation.
   always_comb begin
      hit_s = 1'b0;
      case (mode_r)
         MODE_A:   hit_s = in_a_s;
         MODE_AND: hit_s = in_a_s & in_b_s;
         MODE_XOR: hit_s = in_a_s ^ in_b_s;
`ifdef SET_MODE3_EN
         MODE_TWO: hit_s = (({1'b0, in_a_s} + {1'b0, in_b_s} + {1'b0, in_c_s}) == 2'd2);
`else
         MODE_TWO: hit_s = 1'b0;
`endif
         default:  hit_s = 1'b0;
      endcase
   end

   // Control FSM, point counter, accumulator and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         mode_r  <= MODE_A;
         cen_r   <= 24'd0;
         rad_r   <= 12'd0;
         pt_r    <= 6'd0;
         cnt_r   <= 7'd0;
         cand_r  <= 8'd0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_CALC: begin
               cnt_r <= cnt_r + {6'd0, hit_s};
               pt_r  <= pt_r + 6'd1;
               if (pt_r == LAST_PT) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  valid_r <= 1'b1;
                  cand_r  <= {1'b0, cnt_r + {6'd0, hit_s}};
               end else begin
                  state_r <= ST_CALC;
               end
            end
            // DONE accepts a new start just like IDLE does.
            ST_IDLE, ST_DONE: begin
               valid_r <= 1'b0;
               if (en) begin
                  state_r <= ST_CALC;
                  busy_r  <= 1'b1;
                  cen_r   <= central;
                  rad_r   <= radius;
                  mode_r  <= mode_e'(mode);
                  pt_r    <= 6'd0;
                  cnt_r   <= 7'd0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign valid     = valid_r;
   assign candidate = cand_r;

endmodule

// File: tb/tb_set_core.sv
// Self-checking bench for set_core: directed cases, en-during-busy, mid-run reset and random back-to-back runs.
module tb_set_core;

   logic        clk;
   logic        rst;
   logic        en;
   logic [23:0] central;
   logic [11:0] radius;
   logic [1:0]  mode;
   logic        busy;
   logic        valid;
   logic [7:0]  candidate;

   int checks   = 0;
   int failures = 0;

   set_core dut (
      .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
      .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: brute-force count over the grid with plain integer geometry.
   function automatic int ref_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
      int xs[3], ys[3], rs[3];
      int n = 0;
      bit ins[3];
      for (int k = 0; k < 3; k++) begin
         xs[k] = int'((c >> (20 - 8*k)) & 24'hF);
         ys[k] = int'((c >> (16 - 8*k)) & 24'hF);
         rs[k] = int'((r >> (8 - 4*k)) & 12'hF);
      end
      for (int y = 1; y <= 8; y++) begin
         for (int x = 1; x <= 8; x++) begin
            for (int k = 0; k < 3; k++)
               ins[k] = ((x - xs[k])*(x - xs[k]) + (y - ys[k])*(y - ys[k])) <= rs[k]*rs[k];
            case (m)
               2'd0: n += ins[0] ? 1 : 0;
               2'd1: n += (ins[0] && ins[1]) ? 1 : 0;
               2'd2: n += (ins[0] != ins[1]) ? 1 : 0;
               default: begin
`ifdef SET_MODE3_EN
                  n += ((int'(ins[0]) + int'(ins[1]) + int'(ins[2])) == 2) ? 1 : 0;
`else
                  n += 0;
`endif
               end
            endcase
         end
      end
      return n;
   endfunction

   // Called at a negedge: pulses en, then waits (bounded) for valid and checks the result.
   task automatic do_run(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input bit poke, output logic [7:0] got);
      int lat;
      central = c; radius = r; mode = m; en = 1'b1;
      @(posedge clk); #1 en = 1'b0;
      lat = 1;
      while (lat < 70) begin
         @(negedge clk);
         if (lat == 1) begin
            check("busy_at_start", busy, 1);
            check("valid_low_at_start", valid, 0);
         end
         if (valid) break;
         if (poke && lat == 20) begin
            en = 1'b1;
            central = $urandom;
            radius = $urandom;
         end else begin
            en = 1'b0;
         end
         @(posedge clk); #1 en = 1'b0;
         lat++;
      end
      check("valid_seen", valid, 1);
      check("latency_le_66", (lat <= 66) ? 1 : 0, 1);
      check("busy_low_at_valid", busy, 0);
      check("candidate_vs_model", candidate, ref_count(c, r, m));
      got = candidate;
   endtask

   // From a valid negedge with no restart: one-cycle pulse and held result.
   task automatic check_hold(input logic [7:0] held, input int idle);
      @(negedge clk);
      check("valid_one_cycle", valid, 0);
      check("candidate_held", candidate, held);
      repeat (idle) @(negedge clk);
      check("candidate_held_idle", candidate, held);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      logic [7:0] got;
      logic [7:0] held;
      int vcount;
      bit restart;
      en = 1'b0; central = 24'd0; radius = 12'd0; mode = 2'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_valid", valid, 0);
      check("reset_candidate", candidate, 0);
      rst = 1'b0;
      @(negedge clk);

      do_run(24'h44_0000, 12'h200, 2'd0, 1'b0, got); check("req024_a_r2", got, 13);
      check_hold(got, 3);
      @(negedge clk);
      do_run(24'h11_0000, 12'h100, 2'd0, 1'b0, got); check("req025_corner", got, 3);
      check_hold(got, 2);
      @(negedge clk);
      do_run(24'h44_0000, 12'h000, 2'd0, 1'b0, got); check("req025_r0", got, 1);
      check_hold(got, 2);
      @(negedge clk);
      do_run(24'h44_5400, 12'h220, 2'd1, 1'b0, got); check("req026_and", got, 8);
      check_hold(got, 2);
      @(negedge clk);
      do_run(24'h44_5400, 12'h220, 2'd2, 1'b1, got); check("req026_xor_en_busy", got, 10);
      check_hold(got, 2);
      @(negedge clk);
`ifdef SET_MODE3_EN
      do_run(24'h44_5488, 12'h222, 2'd3, 1'b0, got); check("req027_two", got, ref_count(24'h44_5488, 12'h222, 2'd3));
      check_hold(got, 1);
      @(negedge clk);
      do_run(24'h44_5488, 12'h220, 2'd3, 1'b0, got); check("req027_two_spec", got, 8);
`else
      do_run(24'h44_5488, 12'h220, 2'd3, 1'b0, got); check("req027_two_off", got, 0);
`endif
      check_hold(got, 1);

      // Mid-run reset: result of the previous run must vanish and no valid may follow.
      @(negedge clk);
      do_run(24'h44_0000, 12'h200, 2'd0, 1'b0, got);
      @(negedge clk);
      central = 24'h44_0000; radius = 12'h300; mode = 2'd0; en = 1'b1;
      @(posedge clk); #1 en = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", valid, 0);
      check("rst_mid_candidate", candidate, 0);
      @(posedge clk); #1 rst = 1'b0;
      vcount = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (valid) vcount++;
      end
      check("no_valid_after_abort", vcount, 0);
      do_run(24'h44_0000, 12'h300, 2'd0, 1'b0, got); check("run_after_reset", got, 29);
      check_hold(got, 1);

      // Random back-to-back runs, sometimes restarting directly from the valid cycle.
      @(negedge clk);
      restart = 1'b0;
      for (int i = 0; i < 64; i++) begin
         do_run($urandom, $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), got);
         held = got;
         restart = ($urandom_range(0, 1) == 1);
         if (!restart) begin
            check_hold(held, $urandom_range(0, 3));
            @(negedge clk);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
